fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the 9-bit accumulator processor; it consumes the control decoder's `jump_en` and branch decisions and produces the address driving instruction ROM. It owns the run/halt handshake with the testbench or top level. Jump and branch targets come from a 32-entry absolute-address lookup table indexed by the low five instruction bits.

---
 rtl/definitions.sv | 26 ++
 rtl/jump_lut.sv | 14 +
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared fetch-unit types and constants: FSM state encoding, default widths,
// and the absolute jump/branch target table.
package definitions;

  localparam int PCW_DEFAULT  = 10;
  localparam int LUTW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // Absolute targets indexed by instruction bits [4:0]; unused entries are 0.
  localparam logic [PCW_DEFAULT-1:0] JUMP_TARGETS [2**LUTW_DEFAULT] = '{
    1: 10'd100,
    2: 10'd200,
    3: 10'd40,
    4: 10'd12,
    5: 10'd1023,
    6: 10'd20,
    7: 10'd30,
    default: 10'd0
  };

endpackage

// File: rtl/jump_lut.sv
// Combinational target ROM: instruction target index -> absolute PC.
module jump_lut
  import definitions::*;
#(
  parameter int PCW  = PCW_DEFAULT,
  parameter int LUTW = LUTW_DEFAULT
) (
  input  logic [LUTW-1:0] TargetIdx,
  output logic [PCW-1:0]  Target
);

  assign Target = PCW'(JUMP_TARGETS[TargetIdx]);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencer for the 9-bit accumulator processor.
// All outputs come from registers or the state register only.
module fetch_unit
  import definitions::*;
#(
  parameter int PCW  = PCW_DEFAULT,
  parameter int LUTW = LUTW_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PCW-1:0]  StartAddr,
  input  logic            Stall,
  input  logic            jump_en,
  input  logic            BranchTaken,
  input  logic [LUTW-1:0] TargetIdx,
  input  logic            HaltReq,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            Fault
);

  fetch_state_t   state;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] target;
  logic           fault;
  logic           pc_at_max;

  jump_lut #(
    .PCW  (PCW),
    .LUTW (LUTW)
  ) u_jump_lut (
    .TargetIdx (TargetIdx),
    .Target    (target)
  );

  assign pc_at_max = &pc;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      fault <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          if (Start) begin
            state <= ST_RUN;
            pc    <= StartAddr;
            fault <= 1'b0;
          end
        end
        ST_RUN: begin
          if (HaltReq) begin
            state <= ST_HALTED;
            fault <= 1'b0;
          end else if (Stall) begin
            pc <= pc;
          end else if (jump_en || BranchTaken) begin
            pc <= target;
          end else if (pc_at_max) begin
            // Running off the end of ROM halts with a fault instead of wrapping.
            state <= ST_HALTED;
            fault <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          pc    <= '0;
          fault <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr = pc;
  assign Running = (state == ST_RUN);
  assign Done    = (state == ST_HALTED);
  assign Fault   = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a model.
module tb_fetch_unit;

  localparam int PCW  = 10;
  localparam int LUTW = 5;
  localparam int PC_MAX = (1 << PCW) - 1;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic [PCW-1:0]  StartAddr;
  logic            Stall;
  logic            jump_en;
  logic            BranchTaken;
  logic [LUTW-1:0] TargetIdx;
  logic            HaltReq;
  logic [PCW-1:0]  ProgCtr;
  logic            Running;
  logic            Done;
  logic            Fault;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.PCW(PCW), .LUTW(LUTW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .jump_en     (jump_en),
    .BranchTaken (BranchTaken),
    .TargetIdx   (TargetIdx),
    .HaltReq     (HaltReq),
    .ProgCtr     (ProgCtr),
    .Running     (Running),
    .Done        (Done),
    .Fault       (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Program's jump table as the bench understands it.
  function automatic int tgt_of(input int idx);
    case (idx)
      1: return 100;
      2: return 200;
      3: return 40;
      4: return 12;
      5: return 1023;
      6: return 20;
      7: return 30;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode  = 0;
  int m_pc    = 0;
  int m_fault = 0;
  bit m_known = 1'b0;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_mode  <= 0;
      m_pc    <= 0;
      m_fault <= 0;
      m_known <= 1'b1;
    end else if (m_mode != 1) begin
      if (Start) begin
        m_mode  <= 1;
        m_pc    <= int'(StartAddr);
        m_fault <= 0;
      end
    end else if (HaltReq) begin
      m_mode  <= 2;
      m_fault <= 0;
    end else if (!Stall) begin
      if (jump_en || BranchTaken)
        m_pc <= tgt_of(int'(TargetIdx));
      else if (m_pc == PC_MAX) begin
        m_mode  <= 2;
        m_fault <= 1;
      end else
        m_pc <= m_pc + 1;
    end
  end

  always @(negedge Clk) begin
    if (m_known) begin
      check("model_pc",      int'(ProgCtr), m_pc);
      check("model_running", int'(Running), int'(m_mode == 1));
      check("model_done",    int'(Done),    int'(m_mode == 2));
      check("model_fault",   int'(Fault),   m_fault);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctl();
    Start = 0; Stall = 0; jump_en = 0; BranchTaken = 0; HaltReq = 0;
    TargetIdx = '0;
  endtask

  task automatic jump_to(input int idx);
    jump_en = 1; TargetIdx = LUTW'(idx);
    step();
    clear_ctl();
  endtask

  task automatic start_at(input int addr);
    Start = 1; StartAddr = PCW'(addr);
    step();
    Start = 0;
  endtask

  initial begin
    Reset = 0; StartAddr = '0;
    clear_ctl();
    step(); step();
    Reset = 1;
    check("reset_pc", int'(ProgCtr), 0);
    check("reset_running", int'(Running), 0);
    check("reset_done", int'(Done), 0);
    check("reset_fault", int'(Fault), 0);

    // Sequential fetch from 5
    start_at(5);
    check("start_pc", int'(ProgCtr), 5);
    check("start_running", int'(Running), 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("incr_pc", int'(ProgCtr), 5 + i);
    end

    // Jump, branch, and both together to LUT[3]=40
    jump_to(4);
    check("jump_to_12", int'(ProgCtr), 12);
    jump_to(3);
    check("jump_en_40", int'(ProgCtr), 40);
    jump_to(4);
    BranchTaken = 1; TargetIdx = 5'd3;
    step(); clear_ctl();
    check("branch_40", int'(ProgCtr), 40);
    jump_to(4);
    jump_en = 1; BranchTaken = 1; TargetIdx = 5'd3;
    step(); clear_ctl();
    check("both_40", int'(ProgCtr), 40);

    // Self-loop at 12 holds until something else happens
    jump_to(4);
    jump_en = 1; TargetIdx = 5'd4;
    step(); step();
    clear_ctl();
    check("self_loop", int'(ProgCtr), 12);

    // Stall overrides jump, jump taken on release
    jump_to(6);
    check("at_20", int'(ProgCtr), 20);
    Stall = 1; jump_en = 1; TargetIdx = 5'd3;
    step();
    check("stall1", int'(ProgCtr), 20);
    step();
    check("stall2", int'(ProgCtr), 20);
    Stall = 0;
    step();
    check("stall_release", int'(ProgCtr), 40);
    HaltReq = 1; jump_en = 1;
    step(); clear_ctl();
    check("halt_pc", int'(ProgCtr), 40);
    check("halt_done", int'(Done), 1);
    check("halt_running", int'(Running), 0);
    check("halt_fault", int'(Fault), 0);

    // PC overflow halts with a fault
    start_at(1022);
    check("top_1022", int'(ProgCtr), 1022);
    step();
    check("top_1023", int'(ProgCtr), 1023);
    step();
    check("ovf_pc", int'(ProgCtr), 1023);
    check("ovf_done", int'(Done), 1);
    check("ovf_fault", int'(Fault), 1);
    step();
    check("ovf_hold", int'(ProgCtr), 1023);
    start_at(0);
    check("restart_pc", int'(ProgCtr), 0);
    check("restart_fault", int'(Fault), 0);
    check("restart_done", int'(Done), 0);

    // Mid-run reset, then Start ignored while running
    jump_to(7);
    check("at_30", int'(ProgCtr), 30);
    Reset = 0; Start = 1; jump_en = 1; StartAddr = 10'd500;
    step();
    Reset = 1; clear_ctl();
    check("midreset_pc", int'(ProgCtr), 0);
    check("midreset_running", int'(Running), 0);
    start_at(30);
    Start = 1; StartAddr = 10'd500;
    step(); Start = 0;
    check("start_in_run", int'(ProgCtr), 31);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      Reset       = ($urandom_range(0, 99) != 0);
      Start       = ($urandom_range(0, 15) == 0);
      StartAddr   = ($urandom_range(0, 3) == 0) ? PCW'($urandom_range(1015, 1023))
                                                : PCW'($urandom_range(0, 1023));
      Stall       = ($urandom_range(0, 3) == 0);
      jump_en     = ($urandom_range(0, 7) == 0);
      BranchTaken = ($urandom_range(0, 7) == 0);
      TargetIdx   = LUTW'($urandom_range(0, 31));
      HaltReq     = ($urandom_range(0, 40) == 0);
      step();
    end

    Reset = 1;
    clear_ctl();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
